// File: rtl/verif_stim_pkg.sv
// Shared types and helpers for the multi-channel valid/ready stimulus generator.
//   mode_t     : data mode encoding (incrementing, LFSR, constant)
//   state_t    : per-channel FSM states
//   LFSR_TAPS  : feedback taps of x^16+x^14+x^13+x^11+1 (left-shifting Fibonacci form)
//   decode_mode: maps the raw 2-bit mode input, treating 2'b11 as incrementing
//   lfsr_step  : one LFSR advance
//   chan_seed  : per-channel seed, base ^ k, never zero
package verif_stim_pkg;

  typedef enum logic [1:0] {
    MODE_INC   = 2'b00,
    MODE_LFSR  = 2'b01,
    MODE_CONST = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_LFSR;
      2'b10:   return MODE_CONST;
      default: return MODE_INC;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] chan_seed(input logic [15:0] base, input int unsigned k);
    logic [15:0] s;
    s = base ^ k[15:0];
    return (s == '0) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/verif_stim_gen_if.sv
// Stream bundle between the stimulus generator and its consumer.
//   i_ready : per-channel ready from the consumer
//   o_valid : per-channel valid
//   o_data  : channel k at [k*DATA_W +: DATA_W]
//   o_count : accepted items per channel, channel k at [k*CNT_W +: CNT_W]
// master = generator side, slave = consumer side.
interface verif_stim_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]        i_ready;
  logic [NUM_CH-1:0]        o_valid;
  logic [NUM_CH*DATA_W-1:0] o_data;
  logic [NUM_CH*CNT_W-1:0]  o_count;

  modport master (input i_ready, output o_valid, output o_data, output o_count);
  modport slave  (output i_ready, input o_valid, input o_data, input o_count);
endinterface

// File: rtl/verif_stim_chan.sv
// One stimulus channel: IDLE -> DRIVE -> DONE FSM, data generator and item counter.
//   clk, rstn (async, active-high), enable, mode, cfg_value, num_items : shared controls
//   i_ready : consumer ready for this channel
//   o_valid, o_data, o_count : registered stream outputs
//   is_done : channel sits in DONE
module verif_stim_chan
  import verif_stim_pkg::*;
#(
  parameter int          DATA_W = 8,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] cfg_value,
  input  logic [CNT_W-1:0]  num_items,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              is_done
);

  state_t            state;
  mode_t             mode_q;
  mode_t             mode_in;
  logic [DATA_W-1:0] cfg_q;
  logic [CNT_W-1:0]  num_q;
  logic [DATA_W-1:0] inc_q;
  logic [15:0]       lfsr_q;
  // Set once a run has started; lets a re-enable after an early stop resume
  // the sequence instead of restarting it. Cleared when a run completes.
  logic              started;

  logic [DATA_W-1:0] inc_nxt;
  logic [15:0]       lfsr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] start_inc;
  logic [15:0]       start_lfsr;

  function automatic logic [DATA_W-1:0] pick(input mode_t m, input logic [DATA_W-1:0] inc,
                                             input logic [15:0] l, input logic [DATA_W-1:0] cfg);
    case (m)
      MODE_LFSR:  return l[DATA_W-1:0];
      MODE_CONST: return cfg;
      default:    return inc;
    endcase
  endfunction

  // Only the generator of the latched mode advances, so a resume in another
  // mode picks up where that mode's sequence last stopped.
  always_comb begin
    mode_in    = decode_mode(mode);
    inc_nxt    = (mode_q == MODE_INC)  ? inc_q + DATA_W'(1) : inc_q;
    lfsr_nxt   = (mode_q == MODE_LFSR) ? lfsr_step(lfsr_q)  : lfsr_q;
    count_nxt  = (o_count == '1) ? o_count : o_count + CNT_W'(1);
    start_inc  = started ? inc_q  : cfg_value;
    start_lfsr = started ? lfsr_q : SEED;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_INC;
      cfg_q   <= '0;
      num_q   <= '0;
      inc_q   <= '0;
      lfsr_q  <= SEED;
      started <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state   <= ST_DRIVE;
            o_valid <= 1'b1;
            mode_q  <= mode_in;
            cfg_q   <= cfg_value;
            num_q   <= num_items;
            inc_q   <= start_inc;
            lfsr_q  <= start_lfsr;
            started <= 1'b1;
            o_data  <= pick(mode_in, start_inc, start_lfsr, cfg_value);
          end
        end
        ST_DRIVE: begin
          // o_valid is always high here, so i_ready alone marks a transfer.
          if (i_ready) begin
            o_count <= count_nxt;
            inc_q   <= inc_nxt;
            lfsr_q  <= lfsr_nxt;
            o_data  <= pick(mode_q, inc_nxt, lfsr_nxt, cfg_q);
            if (num_q != '0 && count_nxt >= num_q) begin
              state   <= ST_DONE;
              o_valid <= 1'b0;
            end else if (!enable) begin
              state   <= ST_IDLE;
              o_valid <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (!enable) begin
            state   <= ST_IDLE;
            o_count <= '0;
            started <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

  assign is_done = (state == ST_DONE);

endmodule

// File: rtl/verif_stim_gen.sv
// Multi-channel valid/ready stimulus generator.
//   clk, rstn (async, active-high)
//   enable, mode, cfg_value, num_items : run controls shared by all channels
//   bus  : stream bundle (i_ready in; o_valid, o_data, o_count out)
//   done : registered AND of all channels being in DONE
module verif_stim_gen
  import verif_stim_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          DATA_W    = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] cfg_value,
  input  logic [CNT_W-1:0]  num_items,
  verif_stim_gen_if.master  bus,
  output logic              done
);

  logic [NUM_CH-1:0]        valid_v;
  logic [NUM_CH*DATA_W-1:0] data_v;
  logic [NUM_CH*CNT_W-1:0]  count_v;
  logic [NUM_CH-1:0]        ch_done;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    verif_stim_chan #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .SEED   (chan_seed(LFSR_SEED, k))
    ) u_chan (
      .clk       (clk),
      .rstn      (rstn),
      .enable    (enable),
      .mode      (mode),
      .cfg_value (cfg_value),
      .num_items (num_items),
      .i_ready   (bus.i_ready[k]),
      .o_valid   (valid_v[k]),
      .o_data    (data_v[k*DATA_W +: DATA_W]),
      .o_count   (count_v[k*CNT_W +: CNT_W]),
      .is_done   (ch_done[k])
    );
  end

  assign bus.o_valid = valid_v;
  assign bus.o_data  = data_v;
  assign bus.o_count = count_v;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) done <= 1'b0;
    else      done <= &ch_done;
  end

endmodule

// File: tb/tb_verif_stim_gen.sv
module tb_verif_stim_gen;
  localparam int NC = 2;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] cfg_value;
  logic [CW-1:0] num_items;
  logic          done;

  verif_stim_gen_if #(.NUM_CH(NC), .DATA_W(DW), .CNT_W(CW)) bus ();

  verif_stim_gen #(.NUM_CH(NC), .DATA_W(DW), .CNT_W(CW), .LFSR_SEED(16'hACE1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .mode      (mode),
    .cfg_value (cfg_value),
    .num_items (num_items),
    .bus       (bus),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per channel run phase (0 idle, 1 streaming, 2 finished),
  // current value of each sequence, latched settings and accepted count.
  int          phase   [NC];
  bit          started [NC];
  logic [DW-1:0] inc_cur [NC];
  logic [15:0] lfsr_cur[NC];
  int          m_l     [NC];
  logic [DW-1:0] cfg_l [NC];
  int          num_l   [NC];
  int          acc     [NC];
  bit          done_exp;
  bit          rand_ready;
  int          hold_left[NC];
  logic [DW-1:0] last_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] seed_of(input int k);
    logic [15:0] s;
    s = 16'hACE1 ^ 16'(k);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
  function automatic logic [15:0] poly_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [DW-1:0] exp_data(input int k);
    if (m_l[k] == 1)      return lfsr_cur[k][DW-1:0];
    else if (m_l[k] == 2) return cfg_l[k];
    else                  return inc_cur[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      phase[k] = 0; started[k] = 0; acc[k] = 0; hold_left[k] = 0;
      inc_cur[k] = '0; lfsr_cur[k] = seed_of(k); m_l[k] = 0; cfg_l[k] = '0; num_l[k] = 0;
    end
    done_exp = 0;
  endtask

  // Check outputs, pick ready, advance one clock, update the model.
  task automatic step();
    bit all_fin;
    for (int k = 0; k < NC; k++) begin
      check($sformatf("ch%0d_valid", k), 32'(bus.o_valid[k]), 32'(phase[k] == 1));
      if (phase[k] == 1)
        check($sformatf("ch%0d_data", k), 32'(bus.o_data[k*DW +: DW]), 32'(exp_data(k)));
      check($sformatf("ch%0d_count", k), 32'(bus.o_count[k*CW +: CW]), 32'(acc[k]));
    end
    check("done", 32'(done), 32'(done_exp));
    if (rand_ready) begin
      for (int k = 0; k < NC; k++) begin
        if (hold_left[k] > 0) begin
          bus.i_ready[k] = 1'b0;
          hold_left[k]--;
        end else begin
          bus.i_ready[k] = 1'b1;
          hold_left[k] = $urandom_range(0, 3);
        end
      end
    end
    @(posedge clk);
    all_fin = 1;
    for (int k = 0; k < NC; k++) if (phase[k] != 2) all_fin = 0;
    for (int k = 0; k < NC; k++) begin
      case (phase[k])
        0: if (enable) begin
          m_l[k]   = (mode == 2'b11) ? 0 : int'(mode);
          cfg_l[k] = cfg_value;
          num_l[k] = int'(num_items);
          if (!started[k]) begin
            inc_cur[k]  = cfg_value;
            lfsr_cur[k] = seed_of(k);
            started[k]  = 1;
          end
          phase[k] = 1;
        end
        1: if (bus.i_ready[k]) begin
          if (acc[k] < 65535) acc[k]++;
          if (m_l[k] == 0) inc_cur[k] = inc_cur[k] + 1'b1;
          if (m_l[k] == 1) lfsr_cur[k] = poly_next(lfsr_cur[k]);
          if (num_l[k] != 0 && acc[k] >= num_l[k]) phase[k] = 2;
          else if (!enable) phase[k] = 0;
        end
        default: if (!enable) begin
          phase[k] = 0; acc[k] = 0; started[k] = 0;
        end
      endcase
    end
    done_exp = all_fin;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b1; enable = 1'b0; mode = 2'b00; cfg_value = '0; num_items = '0;
    bus.i_ready = '0; rand_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_data", 32'(bus.o_data), 32'h0);
    step();
    rstn = 1'b0;
    step();

    // incrementing with wrap, 4 items, full throughput
    mode = 2'b00; cfg_value = 8'hFE; num_items = 16'd4; bus.i_ready = '1; enable = 1'b1;
    step();
    check("t1_ch0_first", 32'(bus.o_data[DW-1:0]), 32'hFE);
    repeat (7) step();
    check("t1_done", 32'(done), 32'h1);
    check("t1_ch1_count", 32'(bus.o_count[CW +: CW]), 32'd4);
    enable = 1'b0;
    repeat (2) step();

    // LFSR, 3 items
    mode = 2'b01; num_items = 16'd3; enable = 1'b1;
    step();
    check("t2_ch0_first", 32'(bus.o_data[DW-1:0]), 32'hE1);
    check("t2_ch1_first", 32'(bus.o_data[DW +: DW]), 32'hE0);
    repeat (6) step();
    enable = 1'b0;
    repeat (2) step();

    // random back-pressure, mode 11 behaves as incrementing
    mode = 2'b11; cfg_value = DW'($urandom); num_items = 16'd20; rand_ready = 1; enable = 1'b1;
    repeat (120) step();
    check("t3_done", 32'(done), 32'h1);
    enable = 1'b0; rand_ready = 0; bus.i_ready = '1;
    repeat (2) step();

    // constant, unlimited
    mode = 2'b10; cfg_value = 8'h3C; num_items = 16'd0; rand_ready = 1; enable = 1'b1;
    repeat (300) step();
    check("t4_done", 32'(done), 32'h0);
    check("t4_valid", 32'(bus.o_valid), 32'h3);
    rand_ready = 0; bus.i_ready = '1; enable = 1'b0;
    repeat (3) step();

    // enable drop with a pending item, then resume
    mode = 2'b00; enable = 1'b1;
    repeat (5) step();
    bus.i_ready = '0; enable = 1'b0;
    repeat (4) step();
    check("t5_held_valid", 32'(bus.o_valid), 32'h3);
    last_d = bus.o_data[DW-1:0];
    bus.i_ready = '1;
    repeat (3) step();
    enable = 1'b1;
    step();
    check("t5_resume", 32'(bus.o_data[DW-1:0]), 32'(last_d + 1'b1));
    repeat (3) step();

    // asynchronous reset mid-stream
    #2 rstn = 1'b1;
    #1;
    check("t6_valid", 32'(bus.o_valid), 32'h0);
    check("t6_count", 32'(bus.o_count), 32'h0);
    check("t6_done", 32'(done), 32'h0);
    model_reset();
    @(negedge clk);
    rstn = 1'b0;
    step();
    check("t6_first", 32'(bus.o_data[DW-1:0]), 32'h3C);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
